ternary_peirce_sign_encoder: RTL and testbench

Streaming inverse of the Peircean sign classifier. It accepts a class number (1–10) on a valid/ready input and emits that class's trichotomy triple (I, II, III) as three serial 2-bit trit beats on a valid/ready output. It sits on the generation side of the semiotic datapath and feeds trit-serial consumers such as the classifier input assembler and the semiosis chain loader. Invalid class numbers are flagged, counted, and either emitted as a fault triple or dropped.

---
 rtl/ternary_peirce_sign_encoder.sv | 166 ++++++++++++++++
 tb/tb_ternary_peirce_sign_encoder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ternary_peirce_sign_encoder.sv
// ternary_peirce_sign_encoder
// Turns a Peircean sign class number (1..10) into its trichotomy triple
// (I, II, III) and streams it out as three 2-bit trit beats.
// Invalid class numbers are flagged, counted, and either emitted as a
// fault triad (FAULT_ON_INVALID=1) or silently dropped.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     class handshake, in_class[3:0] class number
//   out_valid/out_ready   beat handshake
//   out_trit[1:0]         00=-1, 01=0, 10=+1, 11=fault
//   out_pos[1:0]          trichotomy index 0=I, 1=II, 2=III
//   out_last              III beat marker
//   out_fault             beat belongs to an invalid-class triad
//   err_pulse             one cycle after each accepted invalid class
//   busy                  triad in progress
//   sign_count/err_count  saturating statistics counters
//
// state | meaning
// IDLE  | no triad pending, ready for a class
// EMIT  | driving beat 'beat' of the held triple
module ternary_peirce_sign_encoder #(
  parameter bit FAULT_ON_INVALID = 1'b1,
  parameter int CNT_W            = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_class,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_trit,
  output logic [1:0]       out_pos,
  output logic             out_last,
  output logic             out_fault,
  output logic             err_pulse,
  output logic             busy,
  output logic [CNT_W-1:0] sign_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [1:0] beat, beat_nxt;
  logic [5:0] hold, hold_nxt;   // {III, II, I}
  logic       fault, fault_nxt;

  logic       class_ok;
  logic       accept;
  logic       start;
  logic       beat_hs;
  logic       last_hs;

  // Triple packed as {III, II, I}
  function automatic logic [5:0] class_triple(input logic [3:0] c);
    case (c)
      4'd1:    class_triple = 6'b00_00_00;
      4'd2:    class_triple = 6'b00_00_01;
      4'd3:    class_triple = 6'b00_01_01;
      4'd4:    class_triple = 6'b01_01_01;
      4'd5:    class_triple = 6'b00_00_10;
      4'd6:    class_triple = 6'b00_01_10;
      4'd7:    class_triple = 6'b01_01_10;
      4'd8:    class_triple = 6'b00_10_10;
      4'd9:    class_triple = 6'b01_10_10;
      4'd10:   class_triple = 6'b10_10_10;
      default: class_triple = 6'b11_11_11;
    endcase
  endfunction

  assign class_ok = (in_class >= 4'd1) && (in_class <= 4'd10);
  assign accept   = in_valid & in_ready;
  // Dropped invalid classes are accepted but never start a triad
  assign start    = accept & (class_ok | FAULT_ON_INVALID);
  assign beat_hs  = out_valid & out_ready;
  assign last_hs  = beat_hs & (beat == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      beat  <= 2'd0;
      hold  <= 6'd0;
      fault <= 1'b0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      hold  <= hold_nxt;
      fault <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    hold_nxt  = hold;
    fault_nxt = fault;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (start) begin
          state_nxt = EMIT;
          beat_nxt  = 2'd0;
          hold_nxt  = class_triple(in_class);
          fault_nxt = ~class_ok;
        end
      end
      EMIT: begin
        // Only the final beat's handshake frees the holding register
        in_ready = (beat == 2'd2) & out_ready;
        if (beat_hs) begin
          if (beat == 2'd2) begin
            beat_nxt = 2'd0;
            if (start) begin
              state_nxt = EMIT;
              hold_nxt  = class_triple(in_class);
              fault_nxt = ~class_ok;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            beat_nxt = beat + 2'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        beat_nxt  = 2'd0;
      end
    endcase
  end

  logic [1:0] held_trit;
  always_comb begin
    case (beat)
      2'd0:    held_trit = hold[1:0];
      2'd1:    held_trit = hold[3:2];
      default: held_trit = hold[5:4];
    endcase
  end

  assign out_valid = (state == EMIT);
  assign busy      = (state == EMIT);
  assign out_pos   = beat;
  assign out_last  = (state == EMIT) && (beat == 2'd2);
  assign out_fault = (state == EMIT) && fault;
  // Idle bus rests at the neutral trit (0 / Secondness)
  assign out_trit  = (state != EMIT) ? 2'b01 : (fault ? 2'b11 : held_trit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse  <= 1'b0;
      err_count  <= '0;
      sign_count <= '0;
    end else begin
      err_pulse <= accept & ~class_ok;
      if (accept && !class_ok && (err_count != {CNT_W{1'b1}}))
        err_count <= err_count + CNT_W'(1);
      if (last_hs && !fault && (sign_count != {CNT_W{1'b1}}))
        sign_count <= sign_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ternary_peirce_sign_encoder.sv
// Bench for ternary_peirce_sign_encoder: two instances share stimulus,
// A with fault triads and 8-bit counters, B dropping invalid classes with
// 2-bit counters. A beat-queue reference model checks both every cycle;
// a class table and directed sequences cover the corner cases.
module tb_ternary_peirce_sign_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_class;
  logic       out_ready;

  logic       a_in_ready, a_out_valid, a_out_last, a_out_fault, a_err_pulse, a_busy;
  logic [1:0] a_out_trit, a_out_pos;
  logic [7:0] a_sign_count, a_err_count;
  logic       b_in_ready, b_out_valid, b_out_last, b_out_fault, b_err_pulse, b_busy;
  logic [1:0] b_out_trit, b_out_pos;
  logic [1:0] b_sign_count, b_err_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ternary_peirce_sign_encoder #(.FAULT_ON_INVALID(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_class(in_class), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_trit(a_out_trit), .out_pos(a_out_pos), .out_last(a_out_last),
    .out_fault(a_out_fault), .err_pulse(a_err_pulse), .busy(a_busy),
    .sign_count(a_sign_count), .err_count(a_err_count));

  ternary_peirce_sign_encoder #(.FAULT_ON_INVALID(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_class(in_class), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_trit(b_out_trit), .out_pos(b_out_pos), .out_last(b_out_last),
    .out_fault(b_out_fault), .err_pulse(b_err_pulse), .busy(b_busy),
    .sign_count(b_sign_count), .err_count(b_err_count));

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // trip[c] = {III, II, I}; classes enumerate I>=II>=III in lexicographic order
  logic [5:0] trip [16];
  // pending beats: {trit[5:4], pos[3:2], last[1], fault[0]}
  logic [5:0] pend [2][3];
  int  n  [2] = '{0, 0};
  int  sc [2] = '{0, 0};
  int  ec [2] = '{0, 0};
  bit  ep [2] = '{0, 0};
  int  maxc [2] = '{255, 3};
  bit  fen  [2] = '{1'b1, 1'b0};

  task automatic model_step(int m);
    bit rdy;
    logic [5:0] b;
    rdy = (n[m] == 0) || (n[m] == 1 && out_ready);
    ep[m] = 1'b0;
    if (n[m] > 0 && out_ready) begin
      b = pend[m][0];
      if (b[1] && !b[0] && sc[m] < maxc[m]) sc[m]++;
      pend[m][0] = pend[m][1];
      pend[m][1] = pend[m][2];
      n[m]--;
    end
    if (in_valid && rdy) begin
      if (in_class >= 1 && in_class <= 10) begin
        for (int bi = 0; bi < 3; bi++)
          pend[m][bi] = {trip[in_class][2*bi +: 2], 2'(bi), bi == 2, 1'b0};
        n[m] = 3;
      end else begin
        if (ec[m] < maxc[m]) ec[m]++;
        ep[m] = 1'b1;
        if (fen[m]) begin
          for (int bi = 0; bi < 3; bi++)
            pend[m][bi] = {2'b11, 2'(bi), bi == 2, 1'b1};
          n[m] = 3;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        n[m] = 0; sc[m] = 0; ec[m] = 0; ep[m] = 1'b0;
      end
    end else begin
      for (int m = 0; m < 2; m++) model_step(m);
    end
  end

  function automatic logic [31:0] model_exp(int m);
    logic [5:0] front;
    bit rdy;
    rdy   = (n[m] == 0) || (n[m] == 1 && out_ready);
    front = (n[m] > 0) ? pend[m][0] : 6'b01_00_0_0;
    return {6'd0, rdy, n[m] > 0, front, ep[m], n[m] > 0, 8'(sc[m]), 8'(ec[m])};
  endfunction

  initial forever begin
    @(negedge clk);
    chk("cycle_a", {6'd0, a_in_ready, a_out_valid, a_out_trit, a_out_pos, a_out_last,
                    a_out_fault, a_err_pulse, a_busy, a_sign_count, a_err_count},
        model_exp(0));
    chk("cycle_b", {6'd0, b_in_ready, b_out_valid, b_out_trit, b_out_pos, b_out_last,
                    b_out_fault, b_err_pulse, b_busy, 6'd0, b_sign_count, 6'd0, b_err_count},
        model_exp(1));
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    logic [3:0] cls;
    logic [5:0] trits;   // {I, II, III}
    logic       fault;
  } vec_t;
  vec_t vt [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int sc0, ec0, idx;
  logic [5:0] tv;

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_class = 4'd0; out_ready = 1'b1;

    idx = 1;
    for (int k = 0; k < 16; k++) trip[k] = 6'b11_11_11;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j <= i; j++)
        for (int k = 0; k <= j; k++) begin
          trip[idx] = {2'(k), 2'(j), 2'(i)};
          idx++;
        end

    vt[0]  = '{4'd0,  6'b11_11_11, 1'b1};
    vt[1]  = '{4'd1,  6'b00_00_00, 1'b0};
    vt[2]  = '{4'd2,  6'b01_00_00, 1'b0};
    vt[3]  = '{4'd3,  6'b01_01_00, 1'b0};
    vt[4]  = '{4'd4,  6'b01_01_01, 1'b0};
    vt[5]  = '{4'd5,  6'b10_00_00, 1'b0};
    vt[6]  = '{4'd6,  6'b10_01_00, 1'b0};
    vt[7]  = '{4'd7,  6'b10_01_01, 1'b0};
    vt[8]  = '{4'd8,  6'b10_10_00, 1'b0};
    vt[9]  = '{4'd9,  6'b10_10_01, 1'b0};
    vt[10] = '{4'd10, 6'b10_10_10, 1'b0};
    vt[11] = '{4'd11, 6'b11_11_11, 1'b1};
    vt[12] = '{4'd12, 6'b11_11_11, 1'b1};
    vt[13] = '{4'd13, 6'b11_11_11, 1'b1};
    vt[14] = '{4'd14, 6'b11_11_11, 1'b1};
    vt[15] = '{4'd15, 6'b11_11_11, 1'b1};

    #2 rst_n = 1'b0;
    tick(); tick();
    chk("reset_in_ready", a_in_ready, 1);
    chk("reset_trit", a_out_trit, 2'b01);
    rst_n = 1'b1;
    tick();

    // single class 6
    in_valid = 1'b1; in_class = 4'd6;
    tick();
    in_valid = 1'b0;
    chk("c6_b0", {a_out_valid, a_out_trit, a_out_pos, a_out_last}, {1'b1, 2'b10, 2'd0, 1'b0});
    tick();
    chk("c6_b1", {a_out_valid, a_out_trit, a_out_pos, a_out_last}, {1'b1, 2'b01, 2'd1, 1'b0});
    tick();
    chk("c6_b2", {a_out_valid, a_out_trit, a_out_pos, a_out_last}, {1'b1, 2'b00, 2'd2, 1'b1});
    tick();
    chk("c6_count", a_sign_count, 1);

    // every class number through instance A
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_class = vt[i].cls;
      tick();
      in_valid = 1'b0;
      for (int b = 0; b < 3; b++) begin
        tv = vt[i].trits << (2 * b);
        chk("table_beat", {a_out_valid, a_out_trit, a_out_pos, a_out_last, a_out_fault},
            {1'b1, tv[5:4], 2'(b), b == 2, vt[i].fault});
        tick();
      end
    end

    // back-to-back 1 then 10
    sc0 = a_sign_count;
    in_valid = 1'b1; in_class = 4'd1;
    #1 chk("b2b_ready_n", a_in_ready, 1);
    tick();
    in_class = 4'd10;
    #1 chk("b2b_ready_n1", a_in_ready, 0);
    tick();
    #1 chk("b2b_ready_n2", a_in_ready, 0);
    tick();
    #1 chk("b2b_ready_n3", a_in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("b2b_second_b0", {a_out_valid, a_out_trit, a_out_pos}, {1'b1, 2'b10, 2'd0});
    #1 chk("b2b_ready_n4", a_in_ready, 0);
    tick(); tick(); tick();
    chk("b2b_count", a_sign_count - sc0, 2);

    // backpressure on class 8
    in_valid = 1'b1; in_class = 4'd8;
    tick();
    in_valid = 1'b0;
    chk("bp_b0", {a_out_trit, a_out_pos}, {2'b10, 2'd0});
    tick();
    out_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      chk("bp_stall", {a_out_valid, a_out_trit, a_out_pos}, {1'b1, 2'b10, 2'd1});
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_b2", {a_out_trit, a_out_pos, a_out_last}, {2'b00, 2'd2, 1'b1});
    out_ready = 1'b0;
    #1 chk("bp_b2_ready", a_in_ready, 0);
    tick();
    chk("bp_b2_hold", {a_out_valid, a_out_pos}, {1'b1, 2'd2});
    out_ready = 1'b1;
    tick();

    // invalid classes 0 then 12 with fault triads
    sc0 = a_sign_count; ec0 = a_err_count;
    in_valid = 1'b1; in_class = 4'd0;
    tick();
    in_class = 4'd12;
    chk("inv_pulse1", {a_err_pulse, a_out_fault, a_out_trit}, {1'b1, 1'b1, 2'b11});
    tick();
    chk("inv_pulse_off", a_err_pulse, 0);
    tick(); tick();
    in_valid = 1'b0;
    chk("inv_pulse2", {a_err_pulse, a_out_fault, a_out_pos}, {1'b1, 1'b1, 2'd0});
    tick(); tick(); tick();
    chk("inv_err_count", a_err_count - ec0, 2);
    chk("inv_sign_count", a_sign_count, sc0);

    // dropped invalid on B: 15 then 4
    in_valid = 1'b1; in_class = 4'd15;
    tick();
    in_class = 4'd4;
    chk("drop_b", {b_err_pulse, b_out_valid, b_in_ready}, {1'b1, 1'b0, 1'b1});
    tick();
    in_valid = 1'b0;
    chk("drop_b_class4", {b_out_valid, b_out_trit, b_out_pos}, {1'b1, 2'b01, 2'd0});
    repeat (6) tick();

    // reset during beat II of class 9
    in_valid = 1'b1; in_class = 4'd9;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1 chk("rst_mid", {a_out_valid, a_out_trit, a_out_pos, a_busy, a_sign_count, a_err_count},
           {1'b0, 2'b01, 2'd0, 1'b0, 8'd0, 8'd0});
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1; in_class = 4'd2;
    tick();
    in_valid = 1'b0;
    chk("post_rst_b0", a_out_trit, 2'b01);
    tick();
    chk("post_rst_b1", a_out_trit, 2'b00);
    tick(); tick();
    chk("post_rst_count", a_sign_count, 1);

    // saturation of B's 2-bit counter
    in_valid = 1'b1; in_class = 4'd5;
    repeat (15) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("sat_b", b_sign_count, 3);
    chk("sat_a", a_sign_count, 6);

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_class  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'($urandom_range(1, 10));
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 249) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
